// File: rtl/vend_sequencer_if.sv
// Signal bundle between the vend sequencer and the coin validator / dispense / hopper mechanisms.
// The master modport is the sequencer side; the slave modport is the mechanism side.
interface vend_sequencer_if #(
    parameter int CREDIT_W = 5,
    parameter int INV_W    = 6
);
    logic                B1;
    logic                B5;
    logic                B10;
    logic                cancel;
    logic                refill;
    logic                sticla_ack;
    logic                coin_ack;
    logic                STICLA;
    logic                R1;
    logic                R5;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic                short_change;
    logic [CREDIT_W-1:0] owed;
    logic [INV_W-1:0]    inv1_cnt;
    logic [INV_W-1:0]    inv5_cnt;

    modport master (
        input  B1, B5, B10, cancel, refill, sticla_ack, coin_ack,
        output STICLA, R1, R5, coin_reject, credit, short_change, owed, inv1_cnt, inv5_cnt
    );

    modport slave (
        output B1, B5, B10, cancel, refill, sticla_ack, coin_ack,
        input  STICLA, R1, R5, coin_reject, credit, short_change, owed, inv1_cnt, inv5_cnt
    );
endinterface

// File: rtl/vend_sequencer.sv
// Vending transaction controller: credits coins, requests a bottle at PRICE, then pays change
// from the 5-leu and 1-leu hoppers one coin per req/ack handshake, tracking hopper inventory.
module vend_sequencer #(
    parameter int PRICE     = 3,
    parameter int CREDIT_W  = 5,
    parameter int INV_W     = 6,
    parameter int INV1_INIT = 20,
    parameter int INV5_INIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    vend_sequencer_if.master bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VEND   = 3'd1;
    localparam logic [2:0] ST_CHANGE = 3'd2;
    localparam logic [2:0] ST_PAY5   = 3'd3;
    localparam logic [2:0] ST_PAY1   = 3'd4;

    localparam logic [CREDIT_W-1:0] ZERO_C  = {CREDIT_W{1'b0}};
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(32'd1);
    localparam logic [CREDIT_W-1:0] FIVE_C  = CREDIT_W'(32'd5);
    localparam logic [CREDIT_W-1:0] TEN_C   = CREDIT_W'(32'd10);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [INV_W-1:0]    INV_ZERO_C = {INV_W{1'b0}};
    localparam logic [INV_W-1:0]    INV_ONE_C  = INV_W'(32'd1);
    localparam logic [INV_W-1:0]    INV1_C     = INV_W'(INV1_INIT);
    localparam logic [INV_W-1:0]    INV5_C     = INV_W'(INV5_INIT);

    function automatic logic [INV_W-1:0] sat_inc(input logic [INV_W-1:0] v);
        if (v == {INV_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + INV_ONE_C;
        end
    endfunction

    logic [2:0]          state_r, state_s;
    logic [CREDIT_W-1:0] credit_r, credit_s, owed_r, owed_s, add_s, sum_s;
    logic [INV_W-1:0]    inv1_r, inv1_s, inv5_r, inv5_s;
    logic                short_r, short_s, sticla_r, sticla_s, r1_r, r1_s, r5_r, r5_s;
    logic                reject_r, reject_s, any_coin_s;

    // Next-state and next-output computation for the whole transaction.
    always_comb begin
        state_s    = state_r;
        credit_s   = credit_r;
        owed_s     = owed_r;
        short_s    = short_r;
        inv1_s     = inv1_r;
        inv5_s     = inv5_r;
        sticla_s   = sticla_r;
        r1_s       = r1_r;
        r5_s       = r5_r;
        add_s      = ZERO_C;
        sum_s      = credit_r;
        any_coin_s = bus.B1 | bus.B5 | bus.B10;
        reject_s   = any_coin_s;
        case (state_r)
            ST_IDLE: begin
                if (bus.cancel && (credit_r != ZERO_C)) begin
                    state_s = ST_CHANGE;
                end else if (any_coin_s) begin
                    if (bus.B10) begin
                        add_s    = TEN_C;
                        reject_s = bus.B5 | bus.B1;
                    end else if (bus.B5) begin
                        add_s    = FIVE_C;
                        reject_s = bus.B1;
                        inv5_s   = sat_inc(inv5_r);
                    end else begin
                        add_s    = ONE_C;
                        reject_s = 1'b0;
                        inv1_s   = sat_inc(inv1_r);
                    end
                    sum_s = credit_r + add_s;
                    if (sum_s >= PRICE_C) begin
                        credit_s = sum_s - PRICE_C;
                        state_s  = ST_VEND;
                        sticla_s = 1'b1;
                    end else begin
                        credit_s = sum_s;
                    end
                end else begin
                    reject_s = 1'b0;
                end
                // A refill reload overrides any same-cycle inventory increment.
                if (bus.refill) begin
                    inv1_s  = INV1_C;
                    inv5_s  = INV5_C;
                    short_s = 1'b0;
                    owed_s  = ZERO_C;
                end else begin
                    short_s = short_r;
                end
            end
            ST_VEND: begin
                if (bus.sticla_ack) begin
                    sticla_s = 1'b0;
                    state_s  = ST_CHANGE;
                end else begin
                    sticla_s = 1'b1;
                end
            end
            ST_CHANGE: begin
                if ((credit_r >= FIVE_C) && (inv5_r != INV_ZERO_C)) begin
                    state_s = ST_PAY5;
                    r5_s    = 1'b1;
                end else if ((credit_r != ZERO_C) && (inv1_r != INV_ZERO_C)) begin
                    state_s = ST_PAY1;
                    r1_s    = 1'b1;
                end else if (credit_r == ZERO_C) begin
                    state_s = ST_IDLE;
                end else begin
                    short_s  = 1'b1;
                    owed_s   = credit_r;
                    credit_s = ZERO_C;
                    state_s  = ST_IDLE;
                end
            end
            ST_PAY5: begin
                if (bus.coin_ack) begin
                    r5_s     = 1'b0;
                    credit_s = credit_r - FIVE_C;
                    inv5_s   = inv5_r - INV_ONE_C;
                    state_s  = ST_CHANGE;
                end else begin
                    r5_s = 1'b1;
                end
            end
            ST_PAY1: begin
                if (bus.coin_ack) begin
                    r1_s     = 1'b0;
                    credit_s = credit_r - ONE_C;
                    inv1_s   = inv1_r - INV_ONE_C;
                    state_s  = ST_CHANGE;
                end else begin
                    r1_s = 1'b1;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                sticla_s = 1'b0;
                r1_s     = 1'b0;
                r5_s     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops every request without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            credit_r <= ZERO_C;
            owed_r   <= ZERO_C;
            short_r  <= 1'b0;
            inv1_r   <= INV1_C;
            inv5_r   <= INV5_C;
            sticla_r <= 1'b0;
            r1_r     <= 1'b0;
            r5_r     <= 1'b0;
            reject_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            credit_r <= credit_s;
            owed_r   <= owed_s;
            short_r  <= short_s;
            inv1_r   <= inv1_s;
            inv5_r   <= inv5_s;
            sticla_r <= sticla_s;
            r1_r     <= r1_s;
            r5_r     <= r5_s;
            reject_r <= reject_s;
        end
    end

    assign bus.STICLA       = sticla_r;
    assign bus.R1           = r1_r;
    assign bus.R5           = r5_r;
    assign bus.coin_reject  = reject_r;
    assign bus.credit       = credit_r;
    assign bus.short_change = short_r;
    assign bus.owed         = owed_r;
    assign bus.inv1_cnt     = inv1_r;
    assign bus.inv5_cnt     = inv5_r;
endmodule
